// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared types and default sizing for the fixed-priority dispatcher slice.
//   QID_W   : queue-id width for the default queue count
//   STALL_W : stall counter width for the default timeout (saturating count
//             up to and including STALL_TIMEOUT)
//   dispatch_state_t : dispatcher FSM states
//   qid_t   : queue identifier at the default queue count
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int NUMBER_OF_QUEUES_DEFAULT = 4;
    localparam int DATA_WIDTH_DEFAULT       = 64;
    localparam int STALL_TIMEOUT_DEFAULT    = 256;

    localparam int QID_W   = $clog2(NUMBER_OF_QUEUES_DEFAULT);
    localparam int STALL_W = $clog2(STALL_TIMEOUT_DEFAULT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dispatch_state_t;

    typedef logic [QID_W-1:0] qid_t;

endpackage

// File: rtl/fp_out_stage.sv
// ---------------------------------------------------------------------------
// fp_out_stage
// Single-entry registered valid/ready slice carrying {data, last}.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   load               : a beat is being popped this cycle; capture it
//   load_data/last     : beat to capture
//   m_ready            : downstream accepts the held beat
//   accept             : slice can take a new beat this cycle
//   m_valid/data/last  : registered output beat
// ---------------------------------------------------------------------------
module fp_out_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             m_ready,
    output logic             accept,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    // Empty, or the held beat leaves on this edge: either way there is room.
    assign accept = !m_valid || m_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_dispatcher.sv
// ---------------------------------------------------------------------------
// fp_dispatcher
// Locks a grant onto the queue chosen by the fixed-priority selector for one
// whole packet, pops beats from that first-word-fall-through queue and
// forwards them through a registered valid/ready stage. Re-arbitrates only at
// packet boundaries; drops a grant whose queue stays empty mid-packet for
// STALL_TIMEOUT cycles and raises a sticky stall_error.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   selection      : queue id from the selector (sampled only in IDLE)
//   q_empty        : per-queue empty flags
//   q_data         : per-queue head beats, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   q_last         : per-queue head-is-end-of-packet flags
//   q_pop          : one-hot pop, head consumed on the same edge
//   m_data/last/valid, m_ready : registered output beat handshake
//   busy           : grant held (STREAM)
//   grant_id       : locked queue id
//   stall_error    : sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module fp_dispatcher
    import fp_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = NUMBER_OF_QUEUES_DEFAULT,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT,
    parameter int STALL_TIMEOUT    = STALL_TIMEOUT_DEFAULT
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]    selection,
    input  logic [NUMBER_OF_QUEUES-1:0]            q_empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] q_data,
    input  logic [NUMBER_OF_QUEUES-1:0]            q_last,
    output logic [NUMBER_OF_QUEUES-1:0]            q_pop,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic                                   m_last,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   busy,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]    grant_id,
    output logic                                   stall_error
);

    localparam int QW = $clog2(NUMBER_OF_QUEUES);
    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] STALL_LIMIT = CW'(STALL_TIMEOUT - 1);

    dispatch_state_t state, state_next;
    logic [QW-1:0]   grant_next;
    logic [CW-1:0]   stall_cnt, stall_cnt_next;
    logic            stall_error_next;
    logic            accept;
    logic            pop;

    logic                  head_empty;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;

    assign head_empty = q_empty[grant_id];
    assign head_last  = q_last[grant_id];
    assign head_data  = q_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign busy       = (state == STREAM);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        grant_next       = grant_id;
        stall_cnt_next   = stall_cnt;
        stall_error_next = stall_error;
        pop              = 1'b0;

        case (state)
            IDLE: begin
                // An all-empty selector output (tie) simply fails this test.
                stall_cnt_next = '0;
                if (!q_empty[selection]) begin
                    grant_next = selection;
                    state_next = STREAM;
                end
            end

            STREAM: begin
                if (!head_empty) begin
                    // Backpressure with data waiting is not a stall: the
                    // counter only moves while the granted queue is empty.
                    if (accept) begin
                        pop            = 1'b1;
                        stall_cnt_next = '0;
                        if (head_last) begin
                            state_next = IDLE;
                        end
                    end
                end else if (stall_cnt >= STALL_LIMIT) begin
                    stall_error_next = 1'b1;
                    state_next       = IDLE;
                end else begin
                    // Leaving STREAM at the limit keeps the count from ever
                    // passing STALL_TIMEOUT-1, so it cannot wrap.
                    stall_cnt_next = stall_cnt + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        // Reset abandons the packet without consuming anything from the queue.
        if (reset) begin
            pop = 1'b0;
        end
    end

    always_comb begin
        q_pop = '0;
        if (pop) begin
            q_pop[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= '0;
            stall_cnt   <= '0;
            stall_error <= 1'b0;
        end else begin
            state       <= state_next;
            grant_id    <= grant_next;
            stall_cnt   <= stall_cnt_next;
            stall_error <= stall_error_next;
        end
    end

    fp_out_stage #(
        .WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clock     (clock),
        .reset     (reset),
        .load      (pop),
        .load_data (head_data),
        .load_last (head_last),
        .m_ready   (m_ready),
        .accept    (accept),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule

// File: tb/tb_fp_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_fp_dispatcher
// Directed bench for fp_dispatcher (4 queues, 64-bit beats, timeout of 8).
// Each input queue is a small FWFT model; the bench pushes hand-chosen beats
// and checks the dispatcher outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_dispatcher;

    localparam int NQ = 4;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        selection;
    logic [NQ-1:0]     q_empty;
    logic [NQ*DW-1:0]  q_data;
    logic [NQ-1:0]     q_last;
    logic [NQ-1:0]     q_pop;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic [1:0]        grant_id;
    logic              stall_error;

    int checks = 0;
    int errors = 0;

    // FWFT queue models: 64 entries each, wrapping pointers.
    logic [DW-1:0] mem [NQ][64];
    logic          lm  [NQ][64];
    logic [5:0]    rp  [NQ] = '{default: 6'd0};
    logic [5:0]    wp  [NQ] = '{default: 6'd0};

    always #5 clock = ~clock;

    fp_dispatcher #(
        .NUMBER_OF_QUEUES (NQ),
        .DATA_WIDTH       (DW),
        .STALL_TIMEOUT    (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .selection   (selection),
        .q_empty     (q_empty),
        .q_data      (q_data),
        .q_last      (q_last),
        .q_pop       (q_pop),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .stall_error (stall_error)
    );

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]           = (rp[i] == wp[i]);
            q_data[i*DW +: DW]   = mem[i][rp[i]];
            q_last[i]            = lm[i][rp[i]];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < NQ; i++) begin
            if (q_pop[i]) rp[i] <= rp[i] + 6'd1;
        end
    end

    task automatic push(input int q, input logic [DW-1:0] d, input logic l);
        mem[q][wp[q]] = d;
        lm[q][wp[q]]  = l;
        wp[q]         = wp[q] + 6'd1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        selection = 2'd0;
        m_ready   = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_stall_err", 64'(stall_error), 64'd0);
        chk("rst_q_pop", 64'(q_pop), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        reset = 1'b0;

        // All queues empty for 20 cycles: nothing happens
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("idle_q_pop", 64'(q_pop), 64'd0);
            chk("idle_m_valid", 64'(m_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        // Three-beat packet on queue 2
        push(2, 64'hD0, 1'b0);
        push(2, 64'hD1, 1'b0);
        push(2, 64'hD2, 1'b1);
        selection = 2'd2;
        #1;
        chk("p3_idle_busy", 64'(busy), 64'd0);
        chk("p3_idle_no_pop", 64'(q_pop), 64'd0);
        @(negedge clock);
        chk("p3_busy", 64'(busy), 64'd1);
        chk("p3_grant", 64'(grant_id), 64'd2);
        chk("p3_pop0", 64'(q_pop), 64'b0100);
        chk("p3_no_valid_yet", 64'(m_valid), 64'd0);
        @(negedge clock);
        chk("p3_d0_valid", 64'(m_valid), 64'd1);
        chk("p3_d0", m_data, 64'hD0);
        chk("p3_d0_last", 64'(m_last), 64'd0);
        chk("p3_pop1", 64'(q_pop), 64'b0100);
        @(negedge clock);
        chk("p3_d1", m_data, 64'hD1);
        chk("p3_d1_last", 64'(m_last), 64'd0);
        chk("p3_pop2", 64'(q_pop), 64'b0100);
        @(negedge clock);
        chk("p3_d2", m_data, 64'hD2);
        chk("p3_d2_last", 64'(m_last), 64'd1);
        chk("p3_busy_drop", 64'(busy), 64'd0);
        chk("p3_pop_done", 64'(q_pop), 64'd0);
        @(negedge clock);
        chk("p3_drained", 64'(m_valid), 64'd0);

        // Four-beat packet on queue 2; selection moves to queue 0 mid-packet
        push(2, 64'hA0, 1'b0);
        push(2, 64'hA1, 1'b0);
        push(2, 64'hA2, 1'b0);
        push(2, 64'hA3, 1'b1);
        push(0, 64'hB0, 1'b1);
        #1;
        @(negedge clock);
        chk("pe_grant2", 64'(grant_id), 64'd2);
        chk("pe_pop_q2", 64'(q_pop), 64'b0100);
        @(negedge clock);
        chk("pe_a0", m_data, 64'hA0);
        selection = 2'd0;
        #1;
        chk("pe_no_preempt_pop", 64'(q_pop), 64'b0100);
        @(negedge clock);
        chk("pe_a1", m_data, 64'hA1);
        chk("pe_grant_held", 64'(grant_id), 64'd2);
        @(negedge clock);
        chk("pe_a2", m_data, 64'hA2);
        @(negedge clock);
        chk("pe_a3", m_data, 64'hA3);
        chk("pe_a3_last", 64'(m_last), 64'd1);
        chk("pe_bubble_busy", 64'(busy), 64'd0);
        chk("pe_bubble_pop", 64'(q_pop), 64'd0);
        @(negedge clock);
        chk("pe_q0_busy", 64'(busy), 64'd1);
        chk("pe_q0_grant", 64'(grant_id), 64'd0);
        chk("pe_q0_pop", 64'(q_pop), 64'b0001);
        chk("pe_a3_drained", 64'(m_valid), 64'd0);
        @(negedge clock);
        chk("pe_b0", m_data, 64'hB0);
        chk("pe_b0_last", 64'(m_last), 64'd1);
        chk("pe_b0_busy", 64'(busy), 64'd0);
        @(negedge clock);
        chk("pe_b0_drained", 64'(m_valid), 64'd0);

        // Backpressure mid-packet on queue 3, longer than the stall timeout
        push(3, 64'hC0, 1'b0);
        push(3, 64'hC1, 1'b0);
        push(3, 64'hC2, 1'b0);
        push(3, 64'hC3, 1'b1);
        selection = 2'd3;
        #1;
        @(negedge clock);
        chk("bp_grant", 64'(grant_id), 64'd3);
        chk("bp_pop", 64'(q_pop), 64'b1000);
        @(negedge clock);
        chk("bp_c0", m_data, 64'hC0);
        m_ready = 1'b0;
        #1;
        chk("bp_no_pop", 64'(q_pop), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("bp_hold_valid", 64'(m_valid), 64'd1);
            chk("bp_hold_data", m_data, 64'hC0);
            chk("bp_hold_no_pop", 64'(q_pop), 64'd0);
            chk("bp_hold_busy", 64'(busy), 64'd1);
            chk("bp_hold_no_stall", 64'(stall_error), 64'd0);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_resume_pop", 64'(q_pop), 64'b1000);
        @(negedge clock);
        chk("bp_c1", m_data, 64'hC1);
        @(negedge clock);
        chk("bp_c2", m_data, 64'hC2);
        @(negedge clock);
        chk("bp_c3", m_data, 64'hC3);
        chk("bp_c3_last", 64'(m_last), 64'd1);
        chk("bp_busy_drop", 64'(busy), 64'd0);
        @(negedge clock);
        chk("bp_drained", 64'(m_valid), 64'd0);
        chk("bp_no_stall_err", 64'(stall_error), 64'd0);

        // Queue 1 runs dry after its first beat: timeout after 8 empty cycles
        push(1, 64'hE0, 1'b0);
        selection = 2'd1;
        #1;
        @(negedge clock);
        chk("st_grant", 64'(grant_id), 64'd1);
        chk("st_pop", 64'(q_pop), 64'b0010);
        @(negedge clock);
        chk("st_e0", m_data, 64'hE0);
        chk("st_e0_valid", 64'(m_valid), 64'd1);
        chk("st_e1_no_pop", 64'(q_pop), 64'd0);
        chk("st_e1_busy", 64'(busy), 64'd1);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clock);
            chk("st_wait_busy", 64'(busy), 64'd1);
            chk("st_wait_no_err", 64'(stall_error), 64'd0);
            chk("st_wait_no_pop", 64'(q_pop), 64'd0);
            chk("st_wait_no_beat", 64'(m_valid), 64'd0);
        end
        @(negedge clock);
        chk("st_err_set", 64'(stall_error), 64'd1);
        chk("st_busy_drop", 64'(busy), 64'd0);
        chk("st_no_fake_beat", 64'(m_valid), 64'd0);
        push(3, 64'hF0, 1'b1);
        selection = 2'd3;
        #1;
        @(negedge clock);
        chk("st_regrant_busy", 64'(busy), 64'd1);
        chk("st_regrant_id", 64'(grant_id), 64'd3);
        chk("st_err_sticky", 64'(stall_error), 64'd1);
        @(negedge clock);
        chk("st_f0", m_data, 64'hF0);
        chk("st_f0_last", 64'(m_last), 64'd1);
        chk("st_f0_busy", 64'(busy), 64'd0);
        @(negedge clock);
        chk("st_f0_drained", 64'(m_valid), 64'd0);

        // Reset mid-packet on queue 2; remaining beats stay queued
        push(2, 64'h60, 1'b0);
        push(2, 64'h61, 1'b0);
        push(2, 64'h62, 1'b1);
        selection = 2'd2;
        #1;
        @(negedge clock);
        chk("rs_grant", 64'(grant_id), 64'd2);
        @(negedge clock);
        chk("rs_valid", 64'(m_valid), 64'd1);
        chk("rs_g0", m_data, 64'h60);
        reset = 1'b1;
        #1;
        chk("rs_no_pop_in_reset", 64'(q_pop), 64'd0);
        @(negedge clock);
        chk("rs_m_valid", 64'(m_valid), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_grant0", 64'(grant_id), 64'd0);
        chk("rs_stall_err", 64'(stall_error), 64'd0);
        chk("rs_m_data", m_data, 64'd0);
        reset = 1'b0;
        #1;
        chk("rs_idle_pop", 64'(q_pop), 64'd0);
        @(negedge clock);
        chk("rs_regrant", 64'(grant_id), 64'd2);
        chk("rs_repop", 64'(q_pop), 64'b0100);
        @(negedge clock);
        chk("rs_g1", m_data, 64'h61);
        chk("rs_g1_last", 64'(m_last), 64'd0);
        @(negedge clock);
        chk("rs_g2", m_data, 64'h62);
        chk("rs_g2_last", 64'(m_last), 64'd1);
        chk("rs_g2_busy", 64'(busy), 64'd0);
        @(negedge clock);
        chk("rs_drained", 64'(m_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
